// File: rtl/outmap_rlc_compressor.sv
// Zero run-length encoder for the ofmap byte stream: one byte per cycle in,
// (run, value) pairs packed four to a 64-bit word, handed downstream over valid/ready.
module outmap_rlc_compressor #(
    parameter int RUN_W  = 5,
    parameter int PAIRS  = 4,
    parameter int WORD_W = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [127:0]        outmap_data,
    input  logic [4:0]          outmap_data_valid_num,
    output logic [4:0]          valid_taken_num,
    input  logic                send_done,
    output logic [WORD_W-1:0]   comp_data,
    output logic                comp_valid,
    input  logic                comp_ready,
    output logic                comp_last,
    output logic                frame_done,
    output logic [15:0]         word_count
);

    localparam int PAIR_W = RUN_W + 8;
    localparam int CNT_W  = $clog2(PAIRS + 1);
    localparam int IDX_W  = $clog2(PAIRS);
    localparam int PAD_W  = WORD_W - CNT_W - PAIRS * PAIR_W;
    localparam logic [RUN_W-1:0] RUN_MAX  = '1;
    localparam logic [CNT_W-1:0] ACC_FULL = CNT_W'(PAIRS);

    typedef enum logic [1:0] {ENC, FLUSH_RUN, FLUSH_WORD, DRAIN} state_t;

    state_t                         state, state_next;
    logic [RUN_W-1:0]               run, run_next, run_m1;
    logic [PAIRS-1:0][PAIR_W-1:0]   acc;
    logic [CNT_W-1:0]               acc_cnt;
    logic [WORD_W-1:0]              out_data;
    logic                           out_valid, out_last;

    logic                           take, emit, load, load_last, mark_last, done_pulse;
    logic                           acc_full, out_free, accept;
    logic [PAIR_W-1:0]              emit_pair;
    logic [7:0]                     lane0;
    logic                           unused_lanes;

    assign lane0        = outmap_data[7:0];
    assign unused_lanes = ^outmap_data[127:8];
    assign run_m1       = run - RUN_W'(1);
    assign acc_full     = (acc_cnt == ACC_FULL);
    assign accept       = out_valid && comp_ready;
    assign out_free     = !out_valid || comp_ready;

    always_comb begin
        state_next = state;
        run_next   = run;
        take       = 1'b0;
        emit       = 1'b0;
        emit_pair  = '0;
        load       = 1'b0;
        load_last  = 1'b0;
        mark_last  = 1'b0;
        done_pulse = 1'b0;
        case (state)
            ENC: begin
                // A full acc blocks taking, so a move never coincides with an append.
                if (acc_full && out_free)
                    load = 1'b1;
                if (outmap_data_valid_num != 5'd0 && !acc_full) begin
                    take = 1'b1;
                    if (lane0 != 8'h00 || run == RUN_MAX) begin
                        emit      = 1'b1;
                        emit_pair = {run, lane0};
                        run_next  = '0;
                    end else begin
                        run_next = run + RUN_W'(1);
                    end
                    if (send_done)
                        state_next = FLUSH_RUN;
                end
            end
            FLUSH_RUN: begin
                if (run == '0) begin
                    state_next = FLUSH_WORD;
                end else if (!acc_full) begin
                    emit       = 1'b1;
                    emit_pair  = {run_m1, 8'h00};
                    run_next   = '0;
                    state_next = FLUSH_WORD;
                end else if (out_free) begin
                    // trailing-zeros pair still follows, so this word is not last
                    load = 1'b1;
                end
            end
            FLUSH_WORD: begin
                if (acc_cnt != '0) begin
                    if (out_free) begin
                        load       = 1'b1;
                        load_last  = 1'b1;
                        state_next = DRAIN;
                    end
                end else if (out_valid && !comp_ready) begin
                    mark_last  = 1'b1;
                    state_next = DRAIN;
                end else begin
                    done_pulse = 1'b1;
                    run_next   = '0;
                    state_next = ENC;
                end
            end
            DRAIN: begin
                if (accept) begin
                    done_pulse = 1'b1;
                    run_next   = '0;
                    state_next = ENC;
                end
            end
            default: state_next = ENC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ENC;
            run        <= '0;
            acc        <= '0;
            acc_cnt    <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            word_count <= '0;
        end else begin
            state      <= state_next;
            run        <= run_next;
            frame_done <= done_pulse;
            if (accept)
                out_valid <= 1'b0;
            if (load) begin
                out_data  <= {acc_cnt, {PAD_W{1'b0}}, acc};
                out_valid <= 1'b1;
                out_last  <= load_last;
                acc       <= '0;
                acc_cnt   <= '0;
            end else if (emit) begin
                acc[acc_cnt[IDX_W-1:0]] <= emit_pair;
                acc_cnt                 <= acc_cnt + CNT_W'(1);
            end
            if (mark_last)
                out_last <= 1'b1;
            // count stays visible during the frame_done pulse, then clears
            if (frame_done)
                word_count <= '0;
            else if (accept && word_count != 16'hFFFF)
                word_count <= word_count + 16'd1;
        end
    end

    assign valid_taken_num = {4'b0000, take & rst_n};
    assign comp_data       = out_data;
    assign comp_valid      = out_valid;
    assign comp_last       = out_last;

endmodule

// File: tb/tb_outmap_rlc_compressor.sv
// Scoreboard bench for outmap_rlc_compressor: an upstream byte-queue model feeds frames,
// expected words come from a zero-count reference encoder.
module tb_outmap_rlc_compressor;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [63:0] data;
        logic        last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] outmap_data;
    logic [4:0]   outmap_data_valid_num;
    logic [4:0]   valid_taken_num;
    logic         send_done;
    logic [63:0]  comp_data;
    logic         comp_valid;
    logic         comp_ready;
    logic         comp_last;
    logic         frame_done;
    logic [15:0]  word_count;

    int total = 0;
    int bad   = 0;

    logic [8:0] up_q[$];
    exp_t       exp_q[$];
    logic       stall = 1'b0;
    int         frames_exp  = 0;
    int         frames_done = 0;

    outmap_rlc_compressor #(.RUN_W(5), .PAIRS(4), .WORD_W(64)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .outmap_data           (outmap_data),
        .outmap_data_valid_num (outmap_data_valid_num),
        .valid_taken_num       (valid_taken_num),
        .send_done             (send_done),
        .comp_data             (comp_data),
        .comp_valid            (comp_valid),
        .comp_ready            (comp_ready),
        .comp_last             (comp_last),
        .frame_done            (frame_done),
        .word_count            (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference: count zeros, spill full 32-zero pairs, then tag the run onto the next value.
    task automatic push_frame(input byte_q_t b);
        logic [12:0] pairs[$];
        int unsigned z = 0;
        exp_t        e;
        foreach (b[i]) begin
            up_q.push_back({(i == b.size() - 1), b[i]});
            if (b[i] == 8'h00) begin
                z++;
            end else begin
                while (z >= 32) begin pairs.push_back({5'd31, 8'h00}); z -= 32; end
                pairs.push_back({5'(z), b[i]});
                z = 0;
            end
        end
        while (z >= 32) begin pairs.push_back({5'd31, 8'h00}); z -= 32; end
        if (z > 0) pairs.push_back({5'(z - 1), 8'h00});
        for (int w = 0; w < pairs.size(); w += 4) begin
            int unsigned n = (pairs.size() - w >= 4) ? 4 : pairs.size() - w;
            e.data = '0;
            e.data[63:61] = 3'(n);
            for (int unsigned k = 0; k < n; k++)
                e.data[13*k +: 13] = pairs[w + k];
            e.last = (w + 4 >= pairs.size());
            exp_q.push_back(e);
        end
        frames_exp++;
    endtask

    task automatic wait_idle();
        int unsigned cyc = 0;
        while ((exp_q.size() != 0 || frames_done < frames_exp) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 2000) check("timeout_idle", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    // Upstream window model
    initial begin
        outmap_data = '0; outmap_data_valid_num = '0; send_done = 1'b0;
        forever begin
            @(negedge clk);
            outmap_data = '0;
            for (int i = 0; i < 16; i++)
                if (i < up_q.size()) outmap_data[8*i +: 8] = up_q[i][7:0];
            outmap_data_valid_num = stall ? 5'd0 : ((up_q.size() > 16) ? 5'd16 : 5'(up_q.size()));
            send_done = (up_q.size() > 0) ? up_q[0][8] : 1'b0;
            #2;
            if (valid_taken_num != 5'd0) begin
                check("take_le_num", 64'(valid_taken_num <= outmap_data_valid_num), 64'd1);
                if (up_q.size() > 0) void'(up_q.pop_front());
            end
        end
    end

    // Output monitor: compares accepted words against the scoreboard
    initial begin
        int   frame_words = 0;
        logic want_done   = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (want_done) begin
                check("frame_done", 64'(frame_done), 64'd1);
                check("wcnt_end", 64'(word_count), 64'(frame_words));
                frames_done++;
                frame_words = 0;
                want_done   = 1'b0;
            end else if (frame_done) begin
                check("done_spurious", 64'd1, 64'd0);
            end
            if (comp_valid && comp_ready && rst_n) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", comp_data, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", comp_data, e.data);
                    check("word_last", 64'(comp_last), 64'(e.last));
                    check("wcnt_run", 64'(word_count), 64'(frame_words));
                    frame_words++;
                    if (e.last) want_done = 1'b1;
                end
            end
        end
    end

    initial begin
        byte_q_t     b;
        logic [63:0] held;
        int unsigned cyc;

        rst_n = 1'b0; comp_ready = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        check("rst_valid", 64'(comp_valid), 64'd0);
        check("rst_data", comp_data, 64'd0);
        check("rst_wcnt", 64'(word_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: mixed zeros and values with trailing zeros
        b = '{8'h05, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        push_frame(b);
        wait_idle();

        // 2: 33 zeros then a value
        b = {};
        repeat (33) b.push_back(8'h00);
        b.push_back(8'h09);
        push_frame(b);
        wait_idle();

        // 3: 12 nonzero bytes under downstream stall
        comp_ready = 1'b0;
        b = {};
        for (int i = 1; i <= 12; i++) b.push_back(8'(i * 3));
        push_frame(b);
        cyc = 0;
        do begin @(negedge clk); #3; cyc++; end while (!comp_valid && cyc < 100);
        check("stall_valid", 64'(comp_valid), 64'd1);
        held = comp_data;
        repeat (10) begin
            @(negedge clk); #3;
            check("stall_hold", comp_data, held);
        end
        check("stall_notake", 64'(valid_taken_num), 64'd0);
        comp_ready = 1'b1;
        wait_idle();

        // 4: exactly two full words, second last
        b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        push_frame(b);
        wait_idle();

        // 5: upstream gap with a pending zero run
        b = '{8'h00, 8'h00};
        foreach (b[i]) up_q.push_back({1'b0, b[i]});
        cyc = 0;
        while (up_q.size() != 0 && cyc < 100) begin @(negedge clk); cyc++; end
        stall = 1'b1;
        b = '{8'h00, 8'h04};
        foreach (b[i]) up_q.push_back({(i == 1), b[i]});
        repeat (5) begin
            @(negedge clk); #3;
            check("gap_notake", 64'(valid_taken_num), 64'd0);
        end
        exp_q.push_back('{data: {3'd1, 9'd0, 39'd0, 5'd3, 8'h04}, last: 1'b1});
        frames_exp++;
        stall = 1'b0;
        wait_idle();

        // 6: reset mid-frame with a word held and a partial accumulator
        comp_ready = 1'b0;
        b = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
        foreach (b[i]) up_q.push_back({1'b0, b[i]});
        cyc = 0;
        while (up_q.size() != 0 && cyc < 100) begin @(negedge clk); cyc++; end
        @(negedge clk); #3;
        check("pre_rst_valid", 64'(comp_valid), 64'd1);
        rst_n = 1'b0;
        @(negedge clk); #3;
        check("mid_rst_valid", 64'(comp_valid), 64'd0);
        check("mid_rst_data", comp_data, 64'd0);
        check("mid_rst_last", 64'(comp_last), 64'd0);
        check("mid_rst_done", 64'(frame_done), 64'd0);
        check("mid_rst_wcnt", 64'(word_count), 64'd0);
        check("mid_rst_take", 64'(valid_taken_num), 64'd0);
        rst_n = 1'b1; comp_ready = 1'b1;
        b = '{8'h00, 8'h00, 8'h03};
        push_frame(b);
        wait_idle();

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
